// File: rtl/seg7_scan.sv
// Time-multiplexed scan driver for a common-anode 7-segment display with tear-free value updates.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [3:0]              num,
  output logic [NUM_DIGITS-1:0]   digit_en_n,
  output logic                    dp_n,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [0:0]            state_q, state_d;
  logic [DW-1:0]         shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
  logic [DW-1:0]         disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic                  pending_q, pending_d;
  logic [3:0]            num_q, num_d;
  logic [NUM_DIGITS-1:0] digit_en_n_q, digit_en_n_d;
  logic                  dp_n_q, dp_n_d;
  logic                  frame_done_q, frame_done_d;

  logic slot_end, frame_end, show_en;

`ifdef SEG7_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lz_blank;
  logic                  seen_nz;
`endif

  // NOTE: combinational blocks use blocking '=' with a default for every output first, so no latch is inferred.
  always_comb begin
    slot_end  = (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);

    state_d = state_q;
    if (state_q == ST_BLANK) begin
      if (cnt_q == CW'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
    end else if (slot_end) begin
      state_d = ST_BLANK;
    end

    // Shadow always takes a load; display only changes at the frame wrap, so a frame is never torn.
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    pending_d    = pending_q;
    if (load) begin
      shadow_val_d = value;
      shadow_dp_d  = dp_in;
    end
    if (frame_end) begin
      pending_d = 1'b0;
      if (load) begin
        disp_val_d = value;
        disp_dp_d  = dp_in;
      end else if (pending_q) begin
        disp_val_d = shadow_val_q;
        disp_dp_d  = shadow_dp_q;
      end
    end else if (load) begin
      pending_d = 1'b1;
    end

    frame_done_d = frame_end;

    // The nibble is set on the edge entering BLANK so it settles before the anode turns on.
    num_d = num_q;
    if (cnt_d == '0) num_d = disp_val_d[{idx_d, 2'b00} +: 4];

`ifdef SEG7_SCAN_LZB_EN
    lz_blank = '0;
    seen_nz  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_val_d[4*i +: 4] != 4'h0) seen_nz = 1'b1;
      lz_blank[i] = ~seen_nz;
    end
    show_en = ~lz_blank[idx_d] | disp_dp_d[idx_d];
`else
    show_en = 1'b1;
`endif

    digit_en_n_d = '1;
    dp_n_d       = 1'b1;
    if (state_d == ST_SHOW) begin
      dp_n_d = ~disp_dp_d[idx_d];
      if (show_en) digit_en_n_d[idx_d] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      state_q      <= ST_BLANK;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      pending_q    <= 1'b0;
      num_q        <= 4'h0;
      digit_en_n_q <= '1;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      pending_q    <= pending_d;
      num_q        <= num_d;
      digit_en_n_q <= digit_en_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign num        = num_q;
  assign digit_en_n = digit_en_n_q;
  assign dp_n       = dp_n_q;
  assign pending    = pending_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2 (frame = 32 cycles).
// Leading-zero expectations follow SEG7_SCAN_LZB_EN when it is defined for the build.
module tb_seg7_scan;

  localparam int ND = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   value = '0;
  logic          load = 1'b0;
  logic [ND-1:0] dp_in = '0;
  logic [3:0]    num;
  logic [ND-1:0] digit_en_n;
  logic          dp_n;
  logic          pending;
  logic          frame_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  seg7_scan #(.NUM_DIGITS(ND), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
    .num(num), .digit_en_n(digit_en_n), .dp_n(dp_n), .pending(pending),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;
    logic [3:0] num;
    logic [3:0] en_n;
    logic       dp_n;
    logic       fd;
    logic       pend;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic go_to(input int target);
    while (cyc < target) tick();
  endtask

  // Drive a one-cycle load during cycle 'at'; it is sampled on the edge into at+1.
  task automatic do_load(input int at, input logic [15:0] v, input logic [3:0] dp);
    go_to(at);
    value = v;
    dp_in = dp;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_num"},  32'(num), 32'h0);
    check({tag, "_en"},   32'(digit_en_n), 32'hF);
    check({tag, "_dp"},   32'(dp_n), 32'h1);
    check({tag, "_pend"}, 32'(pending), 32'h0);
    check({tag, "_fd"},   32'(frame_done), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_en2, exp_en3;

    vecs[0]  = '{0,  4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1,  4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{2,  4'h0, 4'b1110, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{7,  4'h0, 4'b1110, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{8,  4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{10, 4'h0, 4'b1101, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{18, 4'h0, 4'b1011, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{26, 4'h0, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{31, 4'h0, 4'b0111, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{32, 4'h0, 4'b1111, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{33, 4'h0, 4'b1111, 1'b1, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    #2 rst_n = 1'b1;
    cyc = 0;

    // First frame after reset
    for (int i = 0; i < 11; i++) begin
      go_to(vecs[i].c);
      check($sformatf("f0_num_%0d", i),  32'(num), 32'(vecs[i].num));
      check($sformatf("f0_en_%0d", i),   32'(digit_en_n), 32'(vecs[i].en_n));
      check($sformatf("f0_dp_%0d", i),   32'(dp_n), 32'(vecs[i].dp_n));
      check($sformatf("f0_fd_%0d", i),   32'(frame_done), 32'(vecs[i].fd));
      check($sformatf("f0_pend_%0d", i), 32'(pending), 32'(vecs[i].pend));
    end

    // Mid-frame load waits for the boundary at cycle 64
    do_load(33, 16'h1A2F, 4'b0000);
    check("ld_pend", 32'(pending), 32'h1);
    go_to(42); check("old_num_d1", 32'(num), 32'h0);
    go_to(63); check("pre_bnd_pend", 32'(pending), 32'h1);
    go_to(64);
    check("bnd_fd", 32'(frame_done), 32'h1);
    check("bnd_num", 32'(num), 32'hF);
    check("bnd_pend", 32'(pending), 32'h0);
    go_to(66); check("n1_d0", 32'(num), 32'hF); check("n1_en0", 32'(digit_en_n), 32'hE);
    go_to(74); check("n1_d1", 32'(num), 32'h2);
    go_to(82); check("n1_d2", 32'(num), 32'hA);
    go_to(90); check("n1_d3", 32'(num), 32'h1); check("n1_en3", 32'(digit_en_n), 32'h7);

    // Two loads in one frame: last one wins
    do_load(100, 16'h1111, 4'b0000);
    do_load(110, 16'h2222, 4'b0000);
    check("ll_pend", 32'(pending), 32'h1);
    for (int s = 0; s < 4; s++) begin
      go_to(130 + 8 * s);
      check($sformatf("ll_num_d%0d", s), 32'(num), 32'h2);
    end

    // Load exactly on the wrap edge goes straight to the display
    do_load(159, 16'hBEEF, 4'b0000);
    check("bd_fd", 32'(frame_done), 32'h1);
    check("bd_num", 32'(num), 32'hF);
    check("bd_pend", 32'(pending), 32'h0);
    go_to(162); check("bd_d0", 32'(num), 32'hF);
    go_to(170); check("bd_d1", 32'(num), 32'hE);

    // Decimal point on digit 2 only, SHOW phase only
    do_load(170, 16'hBEEF, 4'b0100);
    go_to(178); check("bd_d2", 32'(num), 32'hE); check("dp_old", 32'(dp_n), 32'h1);
    go_to(186); check("bd_d3", 32'(num), 32'hB);
    go_to(192); check("dp_s0b", 32'(dp_n), 32'h1);
    go_to(194); check("dp_s0s", 32'(dp_n), 32'h1);
    go_to(202); check("dp_s1s", 32'(dp_n), 32'h1);
    go_to(208); check("dp_s2b0", 32'(dp_n), 32'h1);
    go_to(209); check("dp_s2b1", 32'(dp_n), 32'h1);
    go_to(210); check("dp_s2s", 32'(dp_n), 32'h0); check("dp_s2en", 32'(digit_en_n), 32'hB);
    go_to(215); check("dp_s2e", 32'(dp_n), 32'h0);
    go_to(216); check("dp_s3b", 32'(dp_n), 32'h1);
    go_to(218); check("dp_s3s", 32'(dp_n), 32'h1);

    // Leading zeros: value 0x0030
    do_load(220, 16'h0030, 4'b0000);
`ifdef SEG7_SCAN_LZB_EN
    exp_en2 = 4'b1111;
    exp_en3 = 4'b1111;
`else
    exp_en2 = 4'b1011;
    exp_en3 = 4'b0111;
`endif
    go_to(226); check("lz_d0_num", 32'(num), 32'h0); check("lz_d0_en", 32'(digit_en_n), 32'hE);
    go_to(234); check("lz_d1_num", 32'(num), 32'h3); check("lz_d1_en", 32'(digit_en_n), 32'hD);
    for (int c = 242; c < 248; c++) begin
      go_to(c);
      check($sformatf("lz_d2_en_%0d", c), 32'(digit_en_n), 32'(exp_en2));
    end
    for (int c = 250; c < 256; c++) begin
      go_to(c);
      check($sformatf("lz_d3_en_%0d", c), 32'(digit_en_n), 32'(exp_en3));
    end

    // Reset mid-SHOW with a pending value
    do_load(262, 16'h1234, 4'b1111);
    go_to(267);
    check("pre_rst_num", 32'(num), 32'h3);
    check("pre_rst_pend", 32'(pending), 32'h1);
    rst_n = 1'b0;
    #2;
    check_reset_vals("mid_rst");
    #2 rst_n = 1'b1;
    cyc = 0;
    go_to(2);  check("post_rst_en", 32'(digit_en_n), 32'hE);
    go_to(32);
    check("post_rst_fd", 32'(frame_done), 32'h1);
    check("post_rst_num", 32'(num), 32'h0);
    check("post_rst_pend", 32'(pending), 32'h0);
    go_to(34); check("post_rst_dp", 32'(dp_n), 32'h1);
    go_to(42); check("post_rst_d1", 32'(num), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
